// File: rtl/nanotrade_feed_tx.sv
// NanoTrade market-feed transmitter: queues typed events and serialises them
// onto the ui/uio pin word, with programmable filler gaps between words.
module nanotrade_feed_tx #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [GAP_W-1:0] gap,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic [1:0]       ev_type,
  input  logic [11:0]      ev_data,
  output logic [7:0]       tx_ui,
  output logic [5:0]       tx_uio,
  output logic             tx_strobe,
  output logic             busy,
  output logic [15:0]      sent_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // Handshake: an event moves into the FIFO on every rising edge where
  // ev_valid && ev_ready; ev_ready depends only on occupancy, never on pops.
  state_t           state;
  logic [13:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [11:0]      last_price;
  logic [13:0]      head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign ev_ready  = !full;
  assign push      = ev_valid && !full;
  assign head      = mem[rd_ptr];
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  // A pop is the moment a word is committed to the pins.
  always_comb begin
    pop = 1'b0;
    if (enable && !empty) begin
      case (state)
        IDLE:    pop = 1'b1;
        SEND:    pop = (gap == '0);
        GAP:     pop = (gap_cnt == GAP_W'(1));
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ev_type, ev_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      last_price <= '0;
      tx_ui      <= '0;
      tx_uio     <= '0;
      tx_strobe  <= 1'b0;
      busy       <= 1'b0;
      sent_count <= '0;
    end else begin
      tx_strobe <= pop;
      if (pop) begin
        tx_ui      <= {head[13:12], head[5:0]};
        tx_uio     <= head[11:6];
        sent_count <= sent_count + 16'd1;
        if (head[13:12] == 2'b00) last_price <= head[11:0];
      end else begin
        // Filler re-asserts the current price so the core sees no spike.
        tx_ui  <= {2'b00, last_price[5:0]};
        tx_uio <= last_price[11:6];
      end
      case (state)
        IDLE: begin
          state <= pop ? SEND : IDLE;
          busy  <= pop || (count_nxt != '0);
        end
        SEND: begin
          gap_cnt <= gap;
          if (pop) begin
            state <= SEND;
            busy  <= 1'b1;
          end else if (gap == '0) begin
            state <= IDLE;
            busy  <= (count_nxt != '0);
          end else begin
            state <= GAP;
            busy  <= 1'b1;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) begin
            state <= pop ? SEND : IDLE;
            busy  <= pop || (count_nxt != '0);
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= (count_nxt != '0);
        end
      endcase
    end
  end

endmodule
